// File: rtl/hyst_link_stream.sv
// rtl/hyst_link_stream.sv - Canny hysteresis linking stage; optional statistics under HYST_STATS_EN
module hyst_link_stream #(
  parameter int MAG_W    = 12,
  parameter int TH_W     = 8,
  parameter int MAX_W    = 1024,
  parameter int DIM_W    = 11,
  parameter int OUT_W    = 8,
  parameter int EDGE_VAL = 0,
  parameter int BG_VAL   = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIM_W-1:0] cfg_width,
  input  logic [DIM_W-1:0] cfg_height,
  input  logic [TH_W-1:0]  th_hi,
  input  logic [TH_W-1:0]  th_lo,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [MAG_W-1:0] s_data,
  input  logic             s_sof,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic             m_user,
  output logic             m_last,
  output logic             err_len,
  output logic             busy
`ifdef HYST_STATS_EN
  ,
  output logic [2*DIM_W-1:0] stat_strong,
  output logic [2*DIM_W-1:0] stat_weak_linked,
  output logic [2*DIM_W-1:0] stat_weak_dropped,
  output logic               stat_valid
`endif
);

  localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2, FLUSH = 2'd3} state_t;
  state_t state, state_nxt;

  logic [DIM_W-1:0] w_q, h_q, col, row;
  logic [TH_W-1:0]  hi_q, lo_q;
  logic             rdy_en, tail, fl_wrap, fl_last, first_pend;
  // Window columns {up, mid, down}: win_a is left of center, win_b is the center column
  logic [5:0]       win_a, win_b;
  logic [1:0]       lb_a [MAX_W];
  logic [1:0]       lb_b [MAX_W];

  logic             out_adv, in_fire, idle_start, px_fire, in_step, fl_step, step;
  logic             col_last, row_last, emit_tail, emit_col, load_out, go_idle;
  logic [TH_W-1:0]  hi_use, lo_use, lo_eff;
  logic [1:0]       cls_in, rd_a, rd_b;
  logic [5:0]       new_col, res_r;
  logic             nb_strong, res_edge;
  logic [AW-1:0]    addr;

  assign addr       = col[AW-1:0];
  assign out_adv    = !m_valid || m_ready;
  assign in_fire    = s_valid && s_ready;
  assign idle_start = in_fire && (state == IDLE) && s_sof;
  assign px_fire    = in_fire && ((state == FILL) || (state == RUN));
  assign in_step    = idle_start || px_fire;
  assign fl_step    = (state == FLUSH) && out_adv && !fl_wrap && !fl_last;
  assign step       = in_step || fl_step;
  assign col_last   = (col == w_q - 1'b1);
  assign row_last   = (row == h_q - 1'b1);
  // The last column of a row is emitted one step late, from the held window with a none right column
  assign emit_tail  = tail && out_adv;
  assign emit_col   = ((px_fire && (state == RUN)) || fl_step) && (col != '0);
  assign load_out   = emit_tail || emit_col;
  assign go_idle    = (state == FLUSH) && fl_last && m_valid && m_ready;

  assign hi_use = (state == IDLE) ? th_hi : hi_q;
  assign lo_use = (state == IDLE) ? th_lo : lo_q;
  assign lo_eff = (lo_use > hi_use) ? hi_use : lo_use;
  assign cls_in = (s_data >= MAG_W'(hi_use)) ? 2'b11 :
                  (s_data >= MAG_W'(lo_eff)) ? 2'b01 : 2'b00;

  assign rd_a    = lb_a[addr];
  assign rd_b    = lb_b[addr];
  assign new_col = {(row == DIM_W'(1)) ? 2'b00 : rd_b, rd_a, (state == FLUSH) ? 2'b00 : cls_in};
  assign res_r   = emit_tail ? 6'd0 : new_col;

  assign nb_strong = win_a[5] | win_a[3] | win_a[1] | win_b[5] | win_b[1] |
                     res_r[5] | res_r[3] | res_r[1];
  assign res_edge  = win_b[3] || ((win_b[3:2] == 2'b01) && nb_strong);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (idle_start) state_nxt = FILL;
      FILL:    if (px_fire && col_last) state_nxt = RUN;
      RUN:     if (px_fire && col_last && row_last) state_nxt = FLUSH;
      FLUSH:   if (go_idle) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-derived outputs
  always_comb begin
    busy    = (state != IDLE);
    s_ready = 1'b0;
    case (state)
      IDLE:      s_ready = rdy_en;
      FILL, RUN: s_ready = rdy_en && out_adv;
      default:   s_ready = 1'b0;
    endcase
  end

  // Frame config latch, position counters, window and flush bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en     <= 1'b0;
      w_q        <= '0;
      h_q        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      col        <= '0;
      row        <= '0;
      win_a      <= '0;
      win_b      <= '0;
      tail       <= 1'b0;
      fl_wrap    <= 1'b0;
      fl_last    <= 1'b0;
      first_pend <= 1'b0;
      err_len    <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (idle_start) begin
        w_q        <= cfg_width;
        h_q        <= cfg_height;
        hi_q       <= th_hi;
        lo_q       <= th_lo;
        first_pend <= 1'b1;
      end
      if (in_fire && s_sof && (state != IDLE)) err_len <= 1'b1;
      if (step) begin
        if (col == '0) begin
          win_a <= '0;
          win_b <= new_col;
        end else begin
          win_a <= win_b;
          win_b <= new_col;
        end
      end
      if (idle_start) begin
        col <= DIM_W'(1);
        row <= '0;
      end else if (px_fire || fl_step) begin
        if (col_last) begin
          col <= '0;
          if (px_fire) row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (fl_step && col_last) fl_wrap <= 1'b1;
      if (emit_tail) begin
        tail <= 1'b0;
        if (fl_wrap) fl_last <= 1'b1;
      end
      if (((px_fire && (state == RUN)) || fl_step) && col_last) tail <= 1'b1;
      if (emit_col) first_pend <= 1'b0;
      if (go_idle) begin
        row     <= '0;
        col     <= '0;
        fl_wrap <= 1'b0;
        fl_last <= 1'b0;
      end
    end
  end

  // Output register: loads a verdict when one is ready, otherwise drains on m_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= OUT_W'(BG_VAL);
      m_user  <= 1'b0;
      m_last  <= 1'b0;
    end else if (load_out) begin
      m_valid <= 1'b1;
      m_data  <= res_edge ? OUT_W'(EDGE_VAL) : OUT_W'(BG_VAL);
      m_user  <= emit_col && first_pend;
      m_last  <= emit_tail;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Line buffers: read-before-write shifts row r-1 into the r-2 buffer at the same column
  always_ff @(posedge clk) begin
    if (in_step) begin
      lb_b[addr] <= rd_a;
      lb_a[addr] <= cls_in;
    end
  end

`ifdef HYST_STATS_EN
  logic [1:0] oc_q;
  logic       oe_q;

  // Class and verdict of the pixel currently held in the output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oc_q <= 2'b00;
      oe_q <= 1'b0;
    end else if (load_out) begin
      oc_q <= win_b[3:2];
      oe_q <= res_edge;
    end
  end

  // Saturating per-class counters, cleared at frame start, bumped on accepted outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_strong       <= '0;
      stat_weak_linked  <= '0;
      stat_weak_dropped <= '0;
      stat_valid        <= 1'b0;
    end else begin
      stat_valid <= go_idle;
      if (idle_start) begin
        stat_strong       <= '0;
        stat_weak_linked  <= '0;
        stat_weak_dropped <= '0;
      end else if (m_valid && m_ready) begin
        if (oc_q == 2'b11) begin
          if (stat_strong != '1) stat_strong <= stat_strong + 1'b1;
        end else if (oc_q == 2'b01) begin
          if (oe_q) begin
            if (stat_weak_linked != '1) stat_weak_linked <= stat_weak_linked + 1'b1;
          end else begin
            if (stat_weak_dropped != '1) stat_weak_dropped <= stat_weak_dropped + 1'b1;
          end
        end
      end
    end
  end
`endif

endmodule
